// File: rtl/id_hd_block_assembly_pkg.sv
// Shared widths, types and helpers for the decode-side 8x8 block assembler.
// Coefficients arrive in zig-zag index order; rows are 8 packed 13-bit coefficients.
package id_hd_block_assembly_pkg;

  localparam int COEF_W        = 13;
  localparam int RUN_W         = 4;
  localparam int ROWS          = 8;
  localparam int COEFS_PER_ROW = 8;
  localparam int ROW_W         = COEFS_PER_ROW * COEF_W;
  localparam int BLK_COEFS     = ROWS * COEFS_PER_ROW;
  localparam int IDX_W         = 6;
  localparam int ROW_IDX_W     = 3;

  typedef logic [COEF_W-1:0]    coef_t;
  typedef logic [ROW_W-1:0]     row_t;
  typedef logic [RUN_W-1:0]     run_t;
  typedef logic [IDX_W-1:0]     idx_t;
  typedef logic [ROW_IDX_W-1:0] row_idx_t;

  typedef enum logic [1:0] {
    TOK_NONE,
    TOK_DATA,
    TOK_EOB,
    TOK_OVER
  } tok_kind_e;

  // One extra bit so that idx+run beyond the last coefficient is detectable.
  function automatic logic [IDX_W:0] coef_pos(input idx_t idx, input run_t run);
    return {1'b0, idx} + {{(IDX_W + 1 - RUN_W){1'b0}}, run};
  endfunction

endpackage

// File: rtl/id_hd_block_assembly_if.sv
// Coefficient-token input and row output handshakes of the block assembler.
// The assembler uses the slave view; the producer/consumer side uses master.
interface id_hd_block_assembly_if;
  import id_hd_block_assembly_pkg::*;

  logic  coef_valid;
  logic  coef_ready;
  run_t  coef_run;
  coef_t coef_value;
  logic  coef_eob;
  logic  row_valid;
  logic  row_ready;
  row_t  row_data;
  logic  row_last;
  logic  err_overrun;

  modport slave (
    input  coef_valid, coef_run, coef_value, coef_eob, row_ready,
    output coef_ready, row_valid, row_data, row_last, err_overrun
  );

  modport master (
    output coef_valid, coef_run, coef_value, coef_eob, row_ready,
    input  coef_ready, row_valid, row_data, row_last, err_overrun
  );

endinterface

// File: rtl/id_hd_coef_bank.sv
// One 8x8 coefficient bank: write a single coefficient by zig-zag slot index,
// read a whole 104-bit row, and clear every row in one cycle.
module id_hd_coef_bank
  import id_hd_block_assembly_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     wr_en_i,
  input  idx_t     wr_idx_i,
  input  coef_t    wr_data_i,
  input  logic     clr_i,
  input  row_idx_t rd_row_i,
  output row_t     rd_data_o
);

  row_t rows_w [ROWS];

  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      row_t row_q;
      row_t row_d;

      always_comb begin
        row_d = row_q;
        if (clr_i) begin
          row_d = '0;
        end else if (wr_en_i && (wr_idx_i[5:3] == 3'(gi))) begin
          for (int k = 0; k < COEFS_PER_ROW; k++) begin
            if (wr_idx_i[2:0] == 3'(k)) begin
              row_d[k*COEF_W +: COEF_W] = wr_data_i;
            end
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          row_q <= '0;
        end else begin
          row_q <= row_d;
        end
      end

      assign rows_w[gi] = row_q;
    end
  endgenerate

  assign rd_data_o = rows_w[rd_row_i];

endmodule

// File: rtl/id_hd_block_assembly.sv
// Rebuilds 8x8 coefficient blocks from (run, value, eob) tokens into a ping-pong
// bank pair and streams each finished block out as eight 104-bit rows.
module id_hd_block_assembly
  import id_hd_block_assembly_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  id_hd_block_assembly_if.slave bus
);

  idx_t      idx_q, idx_d;
  logic      wr_bank_q, wr_bank_d;
  logic      rd_bank_q, rd_bank_d;
  row_idx_t  rd_row_q, rd_row_d;
  logic [1:0] bank_full_q, bank_full_d;
  logic      err_q;

  logic [IDX_W:0] pos;
  logic      accept;
  tok_kind_e kind;
  logic      wr_en;
  logic      close;
  logic      row_hs;
  logic      free;
  row_t      bank_rd [2];

  assign pos    = coef_pos(idx_q, bus.coef_run);
  assign accept = bus.coef_valid && bus.coef_ready;

  always_comb begin
    kind = TOK_NONE;
    if (accept) begin
      if (bus.coef_eob) begin
        kind = TOK_EOB;
      end else if (pos[IDX_W]) begin
        kind = TOK_OVER;
      end else begin
        kind = TOK_DATA;
      end
    end
  end

  // Writing the last slot closes the block without waiting for an EOB.
  assign wr_en  = (kind == TOK_DATA);
  assign close  = (kind == TOK_EOB) || (kind == TOK_OVER) ||
                  (wr_en && (pos[IDX_W-1:0] == idx_t'(BLK_COEFS - 1)));
  assign row_hs = bus.row_valid && bus.row_ready;
  assign free   = row_hs && (rd_row_q == row_idx_t'(ROWS - 1));

  always_comb begin
    idx_d       = idx_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    rd_row_d    = rd_row_q;
    bank_full_d = bank_full_q;
    if (close) begin
      idx_d                  = '0;
      wr_bank_d              = ~wr_bank_q;
      bank_full_d[wr_bank_q] = 1'b1;
    end else if (wr_en) begin
      idx_d = pos[IDX_W-1:0] + idx_t'(1);
    end
    // A closing write bank is never the full read bank, so both updates can coexist.
    if (free) begin
      rd_row_d               = '0;
      rd_bank_d              = ~rd_bank_q;
      bank_full_d[rd_bank_q] = 1'b0;
    end else if (row_hs) begin
      rd_row_d = rd_row_q + row_idx_t'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q       <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      rd_row_q    <= '0;
      bank_full_q <= 2'b00;
      err_q       <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      rd_row_q    <= rd_row_d;
      bank_full_q <= bank_full_d;
      err_q       <= (kind == TOK_OVER);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      id_hd_coef_bank u_bank (
        .clk       (clk),
        .rst_n     (reset_n),
        .wr_en_i   (wr_en && (wr_bank_q == 1'(gi))),
        .wr_idx_i  (pos[IDX_W-1:0]),
        .wr_data_i (bus.coef_value),
        .clr_i     (free && (rd_bank_q == 1'(gi))),
        .rd_row_i  (rd_row_q),
        .rd_data_o (bank_rd[gi])
      );
    end
  endgenerate

  assign bus.coef_ready  = ~bank_full_q[wr_bank_q];
  assign bus.row_valid   = bank_full_q[rd_bank_q];
  assign bus.row_data    = bus.row_valid ? bank_rd[rd_bank_q] : '0;
  assign bus.row_last    = (rd_row_q == row_idx_t'(ROWS - 1));
  assign bus.err_overrun = err_q;

endmodule

// File: tb/tb_id_hd_block_assembly.sv
// Directed bench for the block assembler: token streams in, rows out, each
// compared against a small coefficient-array model with immediate assertions.
module tb_id_hd_block_assembly;
  import id_hd_block_assembly_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  id_hd_block_assembly_if bus ();

  id_hd_block_assembly dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  coef_t model [BLK_COEFS];

  task automatic check(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mclear();
    for (int i = 0; i < BLK_COEFS; i++) model[i] = '0;
  endtask

  function automatic row_t model_row(input int r);
    row_t row;
    row = '0;
    for (int k = 0; k < COEFS_PER_ROW; k++) row[k*COEF_W +: COEF_W] = model[r*COEFS_PER_ROW + k];
    return row;
  endfunction

  task automatic send(input int run, input int val, input logic eob);
    int n;
    @(negedge clk);
    bus.coef_valid = 1'b1;
    bus.coef_run   = run_t'(run);
    bus.coef_value = coef_t'(val);
    bus.coef_eob   = eob;
    n = 0;
    while (!bus.coef_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("coef_ready_timeout", bus.coef_ready, 1);
    @(posedge clk);
    $display("token run=%0d value=%0d eob=%0b accepted at %0t", run, val, eob, $time);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.coef_valid = 1'b0;
    bus.coef_eob   = 1'b0;
  endtask

  task automatic read_row(input string tag, input int r);
    int n;
    @(negedge clk);
    bus.row_ready = 1'b1;
    n = 0;
    while (!bus.row_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("%s_r%0d_valid", tag, r), bus.row_valid, 1);
    check($sformatf("%s_r%0d_data", tag, r), bus.row_data, model_row(r));
    check($sformatf("%s_r%0d_last", tag, r), bus.row_last, (r == 7) ? 1 : 0);
    $display("row %s r=%0d data=%h last=%0b", tag, r, bus.row_data, bus.row_last);
    @(posedge clk);
  endtask

  task automatic read_block(input string tag);
    for (int r = 0; r < ROWS; r++) read_row(tag, r);
  endtask

  task automatic rd_stop();
    @(negedge clk);
    bus.row_ready = 1'b0;
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.coef_valid = 1'b0;
    bus.coef_run   = '0;
    bus.coef_value = '0;
    bus.coef_eob   = 1'b0;
    bus.row_ready  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst_row_valid", bus.row_valid, 0);
    check("rst_row_data", bus.row_data, 0);
    check("rst_row_last", bus.row_last, 0);
    check("rst_err", bus.err_overrun, 0);
    check("rst_coef_ready", bus.coef_ready, 1);

    // 1: sparse block closed by EOB; closing edge makes row_valid visible next cycle
    send(0, 5, 1'b0);
    send(2, -3, 1'b0);
    send(0, 0, 1'b1);
    idle();
    check("t1_latency_valid", bus.row_valid, 1);
    mclear();
    model[0] = 13'd5;
    model[3] = 13'h1FFD;
    read_block("t1");
    rd_stop();

    // 2: full 64-token block needs no EOB; following block restarts at idx 0
    for (int i = 0; i < BLK_COEFS; i++) send(0, i, 1'b0);
    send(0, 7, 1'b0);
    send(0, 0, 1'b1);
    idle();
    for (int i = 0; i < BLK_COEFS; i++) model[i] = coef_t'(i);
    read_block("t2a");
    mclear();
    model[0] = 13'd7;
    read_block("t2b");
    rd_stop();

    // 3: reader stalled, two blocks buffered, third waits for a free bank
    send(0, 'h11, 1'b0);
    send(0, 0, 1'b1);
    send(1, 'h22, 1'b0);
    send(0, 0, 1'b1);
    idle();
    check("t3_ready_low", bus.coef_ready, 0);
    check("t3_valid_held", bus.row_valid, 1);
    fork
      begin
        send(2, 'h33, 1'b0);
        send(0, 0, 1'b1);
        idle();
      end
      begin
        mclear(); model[0] = 13'h11; read_block("t3a");
        mclear(); model[1] = 13'h22; read_block("t3b");
        mclear(); model[2] = 13'h33; read_block("t3c");
      end
    join
    rd_stop();
    check("t3_drained", bus.row_valid, 0);

    // 4: idx reaches 60, run 5 overruns: pulse, token dropped, block closed
    send(15, 1, 1'b0);
    send(15, 2, 1'b0);
    send(15, 3, 1'b0);
    send(11, 4, 1'b0);
    send(5, 9, 1'b0);
    idle();
    check("t4_err_pulse", bus.err_overrun, 1);
    check("t4_closed", bus.row_valid, 1);
    @(negedge clk);
    check("t4_err_clear", bus.err_overrun, 0);
    mclear();
    model[15] = 13'd1;
    model[31] = 13'd2;
    model[47] = 13'd3;
    model[59] = 13'd4;
    read_block("t4");
    rd_stop();

    // 5: toggling row_ready, data must hold through each stall
    for (int i = 0; i < BLK_COEFS; i++) send(0, 63 - i, 1'b0);
    idle();
    for (int i = 0; i < BLK_COEFS; i++) model[i] = coef_t'(63 - i);
    for (int r = 0; r < ROWS; r++) begin
      @(negedge clk);
      bus.row_ready = 1'b0;
      check($sformatf("t5_r%0d_stall0", r), bus.row_data, model_row(r));
      @(negedge clk);
      check($sformatf("t5_r%0d_stall1", r), bus.row_data, model_row(r));
      bus.row_ready = 1'b1;
      check($sformatf("t5_r%0d_last", r), bus.row_last, (r == 7) ? 1 : 0);
      $display("row t5 r=%0d data=%h", r, bus.row_data);
      @(posedge clk);
    end
    rd_stop();

    // 6: reset mid-block and mid-read discards everything
    send(0, 'h55, 1'b0);
    send(0, 0, 1'b1);
    send(0, 1, 1'b0);
    send(0, 2, 1'b0);
    idle();
    mclear();
    model[0] = 13'h55;
    read_row("t6pre", 0);
    read_row("t6pre", 1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_valid", bus.row_valid, 0);
    check("t6_rst_data", bus.row_data, 0);
    check("t6_rst_last", bus.row_last, 0);
    check("t6_rst_err", bus.err_overrun, 0);
    bus.row_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("t6_rel_ready", bus.coef_ready, 1);
    check("t6_rel_valid", bus.row_valid, 0);
    send(0, 0, 1'b1);
    idle();
    mclear();
    read_block("t6");
    rd_stop();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
